// File: rtl/max_sel_pipe.sv
// max_sel_pipe: pipelined N-channel max/min selector with optional running-extreme accumulation.
module max_sel_pipe #(
    parameter int N = 4,
    parameter int W = 4,
    parameter int CW = 8,
    localparam int LV = $clog2(N),
    localparam int IDW = (LV > 1) ? LV : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [N*W-1:0]   in_data,
    input  logic             mode_min,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    output logic [W-1:0]     out_value,
    output logic [IDW-1:0]   out_id,
    output logic [CW-1:0]    out_count
);
    localparam int P = 1 << LV;

    // Heap-ordered tree: node n has children 2n and 2n+1; nodes P..2P-1 are the unregistered leaves.
    logic [W-1:0]   nv_q [1:P-1];
    logic [W-1:0]   nv_d [1:P-1];
    logic [IDW-1:0] ni_q [1:P-1];
    logic [IDW-1:0] ni_d [1:P-1];
    logic [W-1:0]   nd_v [1:2*P-1];
    logic [IDW-1:0] nd_i [1:2*P-1];
    logic [LV-1:0]  vld_q, vld_d, mode_q, mode_d, en_q, en_d, clr_q, clr_d;
    logic [LV:0]    va, ma, ea, ca;
    logic           hok_q, hok_d, hm_q, hm_d, ov_q, ov_d, restart, upd;
    logic [W-1:0]   hv_q, hv_d;
    logic [IDW-1:0] hi_q, hi_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    function automatic logic better(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        return m ? (a < b) : (a > b);
    endfunction

    always_comb begin
        va = {in_valid, vld_q};
        ma = {mode_min, mode_q};
        ea = {acc_en, en_q};
        ca = {acc_clr, clr_q};
        vld_d = va[LV:1];
        mode_d = ma[LV:1];
        en_d = ea[LV:1];
        clr_d = ca[LV:1];
        for (int n = 1; n < P; n++) begin
            nd_v[n] = nv_q[n];
            nd_i[n] = ni_q[n];
        end
        // Pad leaves take the worst possible value for the sample's mode.
        for (int k = 0; k < P; k++) begin
            nd_v[P+k] = (k < N) ? in_data[((k < N) ? k : 0)*W +: W] : {W{mode_min}};
            nd_i[P+k] = IDW'(k);
        end
    end

    always_comb begin
        for (int d = 0; d < LV; d++) begin
            for (int n = (1 << d); n < (2 << d); n++) begin
                nv_d[n] = !va[d+1] ? nv_q[n] :
                          better(nd_v[2*n+1], nd_v[2*n], ma[d+1]) ? nd_v[2*n+1] : nd_v[2*n];
                ni_d[n] = !va[d+1] ? ni_q[n] :
                          better(nd_v[2*n+1], nd_v[2*n], ma[d+1]) ? nd_i[2*n+1] : nd_i[2*n];
            end
        end
    end

    always_comb begin
        restart = !en_q[0] || clr_q[0] || !hok_q || (mode_q[0] != hm_q);
        upd = restart || better(nv_q[1], hv_q, mode_q[0]);
        hok_d = hok_q | vld_q[0];
        hm_d = vld_q[0] ? mode_q[0] : hm_q;
        hv_d = (vld_q[0] && upd) ? nv_q[1] : hv_q;
        hi_d = (vld_q[0] && upd) ? ni_q[1] : hi_q;
        cnt_d = !vld_q[0] ? cnt_q : restart ? CW'(1) : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        ov_d = vld_q[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            mode_q <= '0;
            en_q <= '0;
            clr_q <= '0;
            for (int n = 1; n < P; n++) begin
                nv_q[n] <= '0;
                ni_q[n] <= '0;
            end
            hok_q <= 1'b0;
            hm_q <= 1'b0;
            hv_q <= '0;
            hi_q <= '0;
            cnt_q <= '0;
            ov_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            mode_q <= mode_d;
            en_q <= en_d;
            clr_q <= clr_d;
            nv_q <= nv_d;
            ni_q <= ni_d;
            hok_q <= hok_d;
            hm_q <= hm_d;
            hv_q <= hv_d;
            hi_q <= hi_d;
            cnt_q <= cnt_d;
            ov_q <= ov_d;
        end
    end

    assign out_valid = ov_q;
    assign out_value = hv_q;
    assign out_id = hi_q;
    assign out_count = cnt_q;
endmodule

// File: tb/tb_max_sel_pipe.sv
// tb_max_sel_pipe: scoreboard bench for max_sel_pipe (N=4/CW=8 and N=5/CW=2 instances).
module tb_max_sel_pipe;
    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, mode_min = 1'b0, acc_en = 1'b0, acc_clr = 1'b0;
    logic [15:0] a_data = '0;
    logic [19:0] b_data = '0;
    logic a_ov, b_ov;
    logic [3:0] a_v, b_v;
    logic [1:0] a_i, b_c;
    logic [2:0] b_i;
    logic [7:0] a_c;
    int cyc = 0, tests = 0, fails = 0;

    typedef struct {int v; int id; int c; int t;} exp_t;
    exp_t qa[$], qb[$];
    exp_t la = '{0, 0, 0, 0}, lb = '{0, 0, 0, 0};
    bit hok[2], hm[2];
    int hv[2], hid[2], hc[2];
    bit mm;

    max_sel_pipe #(.N(4), .W(4), .CW(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(a_data),
        .mode_min(mode_min), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(a_ov), .out_value(a_v), .out_id(a_i), .out_count(a_c)
    );

    max_sel_pipe #(.N(5), .W(4), .CW(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(b_data),
        .mode_min(mode_min), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(b_ov), .out_value(b_v), .out_id(b_i), .out_count(b_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Linear scan over the real channels, then the accumulation rules applied to the running state.
    task automatic model(input int k, input logic [19:0] d, input int n, input int cmax, output exp_t e);
        int bv, bi, x;
        bv = int'(d[3:0]);
        bi = 0;
        for (int i = 1; i < n; i++) begin
            x = int'((d >> (4 * i)) & 20'hF);
            if (mode_min ? (x < bv) : (x > bv)) begin
                bv = x;
                bi = i;
            end
        end
        if (!acc_en || acc_clr || !hok[k] || (mode_min != hm[k])) begin
            hok[k] = 1'b1;
            hv[k] = bv;
            hid[k] = bi;
            hm[k] = mode_min;
            hc[k] = 1;
        end else begin
            if (mode_min ? (bv < hv[k]) : (bv > hv[k])) begin
                hv[k] = bv;
                hid[k] = bi;
            end
            if (hc[k] < cmax) hc[k]++;
        end
        e = '{hv[k], hid[k], hc[k], cyc};
    endtask

    task automatic drive(input bit v, input logic [15:0] da, input logic [19:0] db,
                         input bit m, input bit en, input bit clr);
        exp_t e;
        @(posedge clk);
        #2;
        in_valid = v;
        a_data = da;
        b_data = db;
        mode_min = m;
        acc_en = en;
        acc_clr = clr;
        if (v) begin
            model(0, {4'h0, da}, 4, 255, e);
            qa.push_back(e);
            model(1, db, 5, 3, e);
            qb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (a_ov) begin
                if (qa.size() == 0) chk("a_spurious_valid", 1, 0);
                else begin
                    la = qa.pop_front();
                    chk("a_value", int'(a_v), la.v);
                    chk("a_id", int'(a_i), la.id);
                    chk("a_count", int'(a_c), la.c);
                    chk("a_latency", cyc - la.t, 3);
                end
            end else begin
                chk("a_hold_value", int'(a_v), la.v);
                chk("a_hold_id", int'(a_i), la.id);
                chk("a_hold_count", int'(a_c), la.c);
            end
            if (b_ov) begin
                if (qb.size() == 0) chk("b_spurious_valid", 1, 0);
                else begin
                    lb = qb.pop_front();
                    chk("b_value", int'(b_v), lb.v);
                    chk("b_id", int'(b_i), lb.id);
                    chk("b_count", int'(b_c), lb.c);
                    chk("b_latency", cyc - lb.t, 4);
                end
            end else begin
                chk("b_hold_value", int'(b_v), lb.v);
                chk("b_hold_id", int'(b_i), lb.id);
                chk("b_hold_count", int'(b_c), lb.c);
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_a_valid"}, int'(a_ov), 0);
        chk({tag, "_a_value"}, int'(a_v), 0);
        chk({tag, "_a_id"}, int'(a_i), 0);
        chk({tag, "_a_count"}, int'(a_c), 0);
        chk({tag, "_b_valid"}, int'(b_ov), 0);
        chk({tag, "_b_count"}, int'(b_c), 0);
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 9) == 0) mm = !mm;
            drive($urandom_range(0, 9) < 8, 16'($urandom), 20'($urandom), mm,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        #1;
        check_zero("reset_init");
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        // Tie on 9 goes to channel 1; min picks channel 3. All-zero N=5 picks channel 0.
        drive(1, 16'h1993, 20'h00000, 0, 0, 0);
        drive(1, 16'h1993, 20'h12345, 1, 0, 0);
        drive(0, 16'hFFFF, 20'hFFFFF, 0, 0, 0);
        drive(1, 16'h8421, 20'h0F0F0, 0, 0, 0);
        drive(1, 16'h4812, 20'hA5A5A, 1, 0, 0);
        // Running maximum 5, 12 (ch2), 7, 12 (ch0 tie keeps ch2).
        drive(1, 16'h0125, 20'h11111, 0, 1, 1);
        drive(1, 16'h0C21, 20'h22222, 0, 1, 0);
        drive(1, 16'h0700, 20'h33333, 0, 1, 0);
        drive(1, 16'h000C, 20'h44444, 0, 1, 0);
        drive(1, 16'h0201, 20'h55555, 0, 1, 1);
        drive(1, 16'h3456, 20'h66666, 1, 1, 0);
        drive(1, 16'h7777, 20'h00007, 1, 1, 0);
        drive(1, 16'h1111, 20'h70000, 1, 1, 0);
        drive(1, 16'hFFFF, 20'hFFFFF, 1, 1, 0);
        random_run(400);
        // Asynchronous reset with samples still in the pipeline.
        drive(1, 16'h9ABC, 20'h9ABCD, 0, 0, 0);
        drive(1, 16'hDEF1, 20'hDEF12, 0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero("reset_mid");
        qa.delete();
        qb.delete();
        hok = '{0, 0};
        la = '{0, 0, 0, 0};
        lb = '{0, 0, 0, 0};
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (6) drive(0, 16'h0, 20'h0, 0, 0, 0);
        random_run(150);
        repeat (8) drive(0, 16'h0, 20'h0, 0, 0, 0);
        chk("a_drain", qa.size(), 0);
        chk("b_drain", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end
endmodule

// File: doc/max_sel_pipe.md
Name: max_sel_pipe

Overview:
- Parametrised, pipelined extreme-value selector that generalises the 4-channel nibble maximum selector.
- Compares N channels of W bits each and returns the winning value and its channel index.
- Runtime mode selects max or min. Optional accumulation keeps the running extreme across consecutive samples.
- Sits between the per-channel data sources and downstream scheduling/arbitration logic in the datapath.

Parameters:
- N, 4, channel count; N >= 2; need not be a power of two.
- W, 4, data width per channel, in bits.
- CW, 8, width of the accumulation sample counter.
- Derived IDW = max(1, clog2(N)), width of the index output.
- Derived LV = clog2(N), number of comparator tree levels.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present on in_data this cycle.
- in_data  in  N*W  packed channels; channel i occupies bits [i*W +: W].
- mode_min  in  1  per-sample select; 0 = find maximum, 1 = find minimum.
- acc_en  in  1  per-sample select; 1 = fold this sample into the running extreme.
- acc_clr  in  1  per-sample select; 1 = this sample starts a new accumulation.
- out_valid  out  1  result present on out_value/out_id/out_count this cycle.
- out_value  out  W  winning value.
- out_id  out  IDW  channel index of the winning value.
- out_count  out  CW  number of samples in the current accumulation, saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - All pipeline valid bits cleared; held accumulator marked invalid.
  - out_valid=0, out_value=0, out_id=0, out_count=0.
  - Any sample in flight is dropped.
  - First valid output after release comes only from a sample accepted after release.
- Pipeline structure:
  - LV registered comparator-tree levels, then 1 registered accumulator stage.
  - A sample presented before rising edge e appears on the outputs after edge e+LV.
  - Latency is LV+1 edges: 3 for N=4, 4 for N=5..8.
- Throughput and bubbles:
  - Throughput is one sample per cycle; there is no backpressure.
  - mode_min, acc_en and acc_clr travel in the pipeline with their sample.
  - A bubble (in_valid=0) propagates as out_valid=0.
  - During a bubble, out_value/out_id/out_count and held state keep their previous values.
- Comparison rules:
  - Unsigned comparison.
  - Ties go to the lower channel index.
  - At each tree node the left (lower-index) operand wins unless the right operand is strictly better: strictly greater in max mode, strictly less in min mode.
- Non-power-of-two N:
  - Tree is padded to 2^LV leaves.
  - Pad leaves carry 0 in max mode and all-ones in min mode, with indices >= N.
  - A pad leaf can never win, because ties favour the lower index.
- Accumulator stage, applied to each valid tree result R with index I:
  - Replace the held value if any of these hold: acc_en=0, acc_clr=1, held invalid, or mode_min differs from the held mode.
    - Held <= (R, I, mode); out_count=1.
  - Otherwise replace the held value only if R is strictly better than held; on a tie the held value and its id stay.
    - out_count increments and saturates at 2^CW-1.
  - Outputs equal the held state after the update.
  - With acc_en=0, out_count=1 on every valid output.
- acc_clr together with acc_en=1 starts a new accumulation seeded by that sample.

Test Plan:
- N=4, W=4, max mode, acc_en=0. in_data channels {A=3, B=9, C=9, D=1} (channel 0 = A) -> 3 cycles later out_valid=1, out_value=9, out_id=1 (tie goes to lower index), out_count=1.
- Same data with mode_min=1 -> out_value=1, out_id=3.
- Back-to-back stream of 4 valid samples with a bubble after the second -> outputs appear in order, each 3 edges after its input; out_valid=0 exactly one cycle; outputs hold their values during the bubble.
- acc_en=1, max mode, samples with maxima 5, 12, 7, 12 (the second 12 on channel 0, the first on channel 2) -> out_value 5, 12, 12, 12; out_id keeps 2 on the tie; out_count 1, 2, 3, 4.
- Mid-accumulation, send one sample with acc_clr=1 and maximum 2 -> out_value=2, out_count=1. Then flip mode_min on the next sample -> accumulation restarts and out_count=1.
- Asynchronous reset asserted with 2 samples in flight -> outputs zero immediately; no stale out_valid after release. Separately, N=5 with all channels 0 in max mode -> out_id=0 (a pad leaf never wins); CW=2 with 5 accumulated samples -> out_count saturates at 3.
